// File: rtl/cirno9_sram_arb.sv
// Single-port SRAM arbiter for cirno9: DBG > (starved IFU) > LSU > IFU, one access per cycle,
// response one cycle after acceptance.
module cirno9_sram_arb #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          dbg_req_valid,
    output logic          dbg_req_ready,
    input  logic          dbg_req_we,
    input  logic [AW-1:0] dbg_req_addr,
    input  logic [31:0]   dbg_req_wdata,
    input  logic [3:0]    dbg_req_wstrb,
    output logic          dbg_rsp_valid,
    output logic [31:0]   dbg_rsp_rdata,

    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_req_we,
    input  logic [AW-1:0] lsu_req_addr,
    input  logic [31:0]   lsu_req_wdata,
    input  logic [3:0]    lsu_req_wstrb,
    output logic          lsu_rsp_valid,
    output logic [31:0]   lsu_rsp_rdata,

    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [AW-1:0] ifu_req_addr,
    output logic          ifu_rsp_valid,
    output logic [31:0]   ifu_rsp_rdata,

    output logic          sram_cs,
    output logic          sram_we,
    output logic [3:0]    sram_wem,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [1:0] {OWN_NONE, OWN_DBG, OWN_LSU, OWN_IFU} owner_e;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    owner_e        grant;
    owner_e        owner;
    logic          owner_we;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_next;
    logic          force_ifu;

    assign force_ifu = (streak == STREAK_MAX) && ifu_req_valid;

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        grant       = OWN_NONE;
        sram_cs     = 1'b0;
        sram_we     = 1'b0;
        sram_wem    = '0;
        sram_addr   = '0;
        sram_wdata  = '0;
        streak_next = streak;

        if (dbg_req_valid)      grant = OWN_DBG;
        else if (force_ifu)     grant = OWN_IFU;
        else if (lsu_req_valid) grant = OWN_LSU;
        else if (ifu_req_valid) grant = OWN_IFU;

        case (grant)
            OWN_DBG: begin
                sram_cs    = 1'b1;
                sram_we    = dbg_req_we;
                sram_wem   = dbg_req_wstrb & {4{dbg_req_we}};
                sram_addr  = dbg_req_addr;
                sram_wdata = dbg_req_wdata;
            end
            OWN_LSU: begin
                sram_cs    = 1'b1;
                sram_we    = lsu_req_we;
                sram_wem   = lsu_req_wstrb & {4{lsu_req_we}};
                sram_addr  = lsu_req_addr;
                sram_wdata = lsu_req_wdata;
            end
            OWN_IFU: begin
                sram_cs   = 1'b1;
                sram_addr = ifu_req_addr;
            end
            default: ;
        endcase

        // DBG-only cycles leave the streak alone; an idle IFU has nothing to starve.
        if (!ifu_req_valid || grant == OWN_IFU)
            streak_next = '0;
        else if (grant == OWN_LSU && streak != STREAK_MAX)
            streak_next = streak + SW'(1);
    end

    assign dbg_req_ready = (grant == OWN_DBG);
    assign lsu_req_ready = (grant == OWN_LSU);
    assign ifu_req_ready = (grant == OWN_IFU);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
            streak   <= '0;
        end else begin
            owner    <= grant;
            owner_we <= sram_we;
            streak   <= streak_next;
        end
    end

    // Read data comes straight from the macro in the response cycle; writes return a zero ack.
    assign dbg_rsp_valid = (owner == OWN_DBG);
    assign lsu_rsp_valid = (owner == OWN_LSU);
    assign ifu_rsp_valid = (owner == OWN_IFU);
    assign dbg_rsp_rdata = (dbg_rsp_valid && !owner_we) ? sram_rdata : '0;
    assign lsu_rsp_rdata = (lsu_rsp_valid && !owner_we) ? sram_rdata : '0;
    assign ifu_rsp_rdata = ifu_rsp_valid ? sram_rdata : '0;

endmodule
